// File: rtl/mnist_pkg.sv
// Shared constants and types for the MNIST pixel feeder.
//   N_PIX : pixels per frame (28x28)
//   DW    : pixel width, Q8.8 signed
//   AW    : pixel address width (2**AW >= N_PIX)
package mnist_pkg;

    localparam int N_PIX = 784;
    localparam int DW    = 16;
    localparam int AW    = 10;

    typedef logic signed [DW-1:0] pixel_t;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/pixel_ram.sv
// Single-clock frame buffer: one write port, one registered read port.
// The array has no reset so it maps onto block RAM. A read of an address
// being written in the same cycle returns the old word.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address (must be < DEPTH to be meaningful)
//   rdata_o : read data, one cycle after raddr_i
module pixel_ram #(
    parameter int DEPTH = 784,
    parameter int W     = 16,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/image_feeder.sv
// Pixel-side responder for the neuron datapath. Collects one frame over a
// valid/ready stream into pixel_ram, pulses nrn_start, then serves the
// neuron's reads until a rising edge on nrn_done re-opens the stream.
//   s_valid/s_data/s_last/s_ready : pixel input stream
//   rd_addr/rd_data               : neuron read port, 1-cycle latency,
//                                   out-of-range addresses read as 0
//   nrn_start                     : 1-cycle start pulse (LAUNCH state)
//   nrn_done                      : neuron done level, rising edge used
//   busy                          : high in LAUNCH/RUN
//   frame_err                     : 1-cycle pulse on a framing violation
//   frame_cnt                     : frames launched, wraps
module image_feeder
    import mnist_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic          s_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          nrn_start,
    input  logic          nrn_done,
    output logic          busy,
    output logic          frame_err,
    output logic [15:0]   frame_cnt
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N_PIX - 1);
    localparam logic [AW-1:0] PIX_LIM  = AW'(N_PIX);

    feeder_state_t state_q;
    logic [AW-1:0] wr_cnt_q;
    logic          done_q;
    logic          start_q;
    logic          err_q;
    logic [15:0]   frame_cnt_q;
    logic          rd_ok_q;    // registered "address was in range"
    pixel_t        ram_q;
    logic          accept;

    // Ready is a pure function of state so it never loops back on s_valid.
    assign s_ready = (state_q == FILL);
    assign busy    = (state_q != FILL);
    assign accept  = s_valid && s_ready;

    pixel_ram #(.DEPTH(N_PIX), .W(DW), .AW(AW)) u_ram (
        .clk     (clk),
        .we_i    (accept),
        .waddr_i (wr_cnt_q),
        .wdata_i (s_data),
        .raddr_i (rd_addr),
        .rdata_o (ram_q)
    );

    // The range flag is reset, so rd_data reads 0 out of reset even though
    // the RAM output register is not.
    assign rd_data   = rd_ok_q ? ram_q : '0;
    assign nrn_start = start_q;
    assign frame_err = err_q;
    assign frame_cnt = frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            wr_cnt_q    <= '0;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            rd_ok_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            err_q   <= 1'b0;
            rd_ok_q <= (rd_addr < PIX_LIM);
            // Sampling done every cycle (including LAUNCH) means a level
            // already high when RUN is entered is never seen as an edge.
            done_q  <= nrn_done;
            case (state_q)
                FILL: begin
                    if (accept) begin
                        if (wr_cnt_q == LAST_IDX) begin
                            // Frame complete; missing s_last is flagged but
                            // the frame is still launched.
                            wr_cnt_q    <= '0;
                            state_q     <= LAUNCH;
                            start_q     <= 1'b1;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            err_q       <= !s_last;
                        end else if (s_last) begin
                            // Short frame: abandon and restart at pixel 0.
                            wr_cnt_q <= '0;
                            err_q    <= 1'b1;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + AW'(1);
                        end
                    end
                end
                LAUNCH: state_q <= RUN;
                RUN: begin
                    if (nrn_done && !done_q) state_q <= FILL;
                end
                default: state_q <= FILL;
            endcase
        end
    end

endmodule

// File: doc/image_feeder.md
Name: image_feeder

Overview:
Pixel-side responder for the neuron datapath. It accepts one MNIST frame of N_PIX 16-bit pixels over a valid/ready stream and stores it in an on-chip buffer. It then pulses start to the neuron and serves the neuron's address requests with a registered 1-cycle read, as the bench memory model does today. New pixels are refused until the neuron's done rises, and then the next frame is accepted.

Parameters:
N_PIX, 784, pixels per frame (28x28)
DW, 16, pixel width (Q8.8 signed)
AW, 10, read/write address width; must satisfy 2**AW >= N_PIX

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input pixel valid
s_data  in  DW  input pixel, signed
s_last  in  1  marks final pixel of frame
s_ready  out  1  feeder can accept a pixel
rd_addr  in  AW  neuron pixel address (neuron's address output)
rd_data  out  DW  pixel at rd_addr, registered (neuron's din_x)
nrn_start  out  1  one-cycle start pulse to neuron
nrn_done  in  1  neuron done, level; only rising edge used
busy  out  1  high in LAUNCH/RUN
frame_err  out  1  one-cycle pulse on s_last framing violation
frame_cnt  out  16  completed frames launched, wraps 0xFFFF->0

Behaviour:
- Reset (async, any state): state=FILL, wr_cnt=0, done_q=0, rd_data=0, nrn_start=0, frame_err=0, frame_cnt=0. Buffer contents are not reset. s_ready=1 from the first cycle after rst_n deasserts.
- States: FILL, LAUNCH, RUN.
- FILL: s_ready=1. Accept when s_valid&&s_ready: mem[wr_cnt]<=s_data, wr_cnt++.
  - Accept with s_last=1 and wr_cnt<N_PIX-1 (short frame): pulse frame_err, wr_cnt<=0, stay FILL. Partial data is abandoned; buffer words may be stale.
  - Accept with wr_cnt==N_PIX-1: frame complete, wr_cnt<=0, go to LAUNCH. If s_last=0, also pulse frame_err (long/missing last); the next pixel starts a new frame.
- LAUNCH (exactly 1 cycle): nrn_start=1, s_ready=0, frame_cnt++; next state RUN.
- RUN: s_ready=0. done_q<=nrn_done every cycle. Rising edge (nrn_done && !done_q) -> FILL. A done level already high on entry is not an edge; done_q is loaded with nrn_done in LAUNCH to guarantee this.
- busy = (state!=FILL), combinational from state.
- Read port: every cycle, in every state, rd_data <= (rd_addr<N_PIX) ? mem[rd_addr] : 0. Latency is 1 cycle; address in cycle n gives data in n+1.
  - Reads during FILL return buffer contents as-is (old or partially new). No read/write bypass: a same-cycle write to the read address returns the old word.
- s_ready depends only on state, never on s_valid (no combinational loop).
- Simultaneous events:
  - nrn_done edge with s_valid high: no pixel is accepted that cycle; acceptance starts the next cycle in FILL.
  - s_valid while s_ready=0: ignored; the source must hold the pixel.
- Back-to-back: a frame can stream with zero bubbles, 784 accepts in 784 cycles. Last accept to nrn_start is 1 cycle.

Decomposition:
- Package mnist_pkg: N_PIX, DW, AW constants, pixel_t (logic signed [DW-1:0]), feeder_state_t enum {FILL, LAUNCH, RUN}.
- Sub-module pixel_ram: single-clock, 1 write + 1 registered read, N_PIX x DW, no reset on the array, infers BRAM. Out-of-range zeroing stays in image_feeder.
- image_feeder holds the FSM, counters and framing check.

Test Plan:
- Stream 784 pixels mem[i]=i, s_last on i=783, no bubbles -> nrn_start high exactly 1 cycle after the last accept, frame_cnt=1, busy=1; rd_addr=5 gives rd_data=0x0005 the next cycle, rd_addr=800 gives 0x0000.
- In RUN, drive s_valid=1 continuously for 50 cycles, then raise nrn_done -> s_ready=0 throughout, no writes (mem[0..783] unchanged); FILL one cycle after the done edge, then accepts resume.
- Hold nrn_done high through completion of frame 2 -> RUN does not exit; drop done for 1 cycle and raise it again -> returns to FILL.
- Short frame: s_last on pixel 99 -> frame_err pulse 1 cycle, no nrn_start. A following full 784-pixel frame launches normally, frame_cnt increments by 1.
- Long frame: 784 pixels with s_last=0 -> frame_err pulse and nrn_start pulse both occur; pixel 785 is accepted only after the done edge, as pixel 0 of the next frame.
- Assert rst_n=0 mid-fill (wr_cnt=400) and mid-RUN -> outputs immediately return to reset values, state FILL, frame_cnt=0; a subsequent full frame launches correctly.
